// File: rtl/lcd_arbiter_pkg.sv
// Shared definitions for the lcd arbiter: FSM state encodings and lcd field widths.
package lcd_arbiter_pkg;

  localparam int LCD_X_W     = 4;
  localparam int LCD_ASCII_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ACK   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/lcd_arbiter_rr_pick.sv
// Combinational round-robin picker: scans last_i+1, last_i+2, ... modulo NUM_REQ
// and returns the first asserted request.
module lcd_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   winner_o
);

  // First asserted request after the last winner wins; the last winner is checked last.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!valid_o && req_i[(int'(last_i) + k) % NUM_REQ]) begin
        valid_o  = 1'b1;
        winner_o = IDX_W'((int'(last_i) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/lcd_arbiter.sv
// Shares one lcd controller between NUM_REQ requesters with round-robin grant.
//
// Handshake (4-phase, level based, same on both sides): the initiator raises
// command with x/y/ascii stable; the responder raises response once it has
// taken the character; the initiator drops command; the responder drops
// response. A new command may only start once response is low again.
module lcd_arbiter
  import lcd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clock_1_6m,
  input  logic                           reset_1_6m,
  input  logic                           clock_valid,
  input  logic [NUM_REQ-1:0]             req_command,
  input  logic [LCD_X_W*NUM_REQ-1:0]     req_x,
  input  logic [NUM_REQ-1:0]             req_y,
  input  logic [LCD_ASCII_W*NUM_REQ-1:0] req_ascii,
  output logic [NUM_REQ-1:0]             req_response,
  output logic                           lcd_command,
  output logic [LCD_X_W-1:0]             lcd_x,
  output logic                           lcd_y,
  output logic [LCD_ASCII_W-1:0]         lcd_ascii,
  input  logic                           lcd_response,
  output logic                           arb_busy,
  output logic [IDX_W-1:0]               grant_idx,
  output state_t                         dbg_state
);

  state_t                   state_q;
  logic [IDX_W-1:0]         grant_q;
  logic [NUM_REQ-1:0]       req_response_q;
  logic                     lcd_command_q;
  logic [LCD_X_W-1:0]       lcd_x_q;
  logic                     lcd_y_q;
  logic [LCD_ASCII_W-1:0]   lcd_ascii_q;

  logic                     grant_valid_d;
  logic [IDX_W-1:0]         grant_d;

  lcd_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req_command),
    .last_i   (grant_q),
    .valid_o  (grant_valid_d),
    .winner_o (grant_d)
  );

  // Arbitration FSM with registered lcd and response outputs; clock_valid=0 freezes everything.
  always_ff @(posedge clock_1_6m) begin
    if (clock_valid) begin
      if (reset_1_6m) begin
        state_q        <= S_IDLE;
        grant_q        <= IDX_W'(NUM_REQ - 1);
        req_response_q <= '0;
        lcd_command_q  <= 1'b0;
        lcd_x_q        <= '0;
        lcd_y_q        <= 1'b0;
        lcd_ascii_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // A stale lcd_response (e.g. after a mid-transaction reset) blocks new grants.
            if (grant_valid_d && !lcd_response) begin
              grant_q       <= grant_d;
              lcd_x_q       <= req_x[int'(grant_d)*LCD_X_W +: LCD_X_W];
              lcd_y_q       <= req_y[grant_d];
              lcd_ascii_q   <= req_ascii[int'(grant_d)*LCD_ASCII_W +: LCD_ASCII_W];
              lcd_command_q <= 1'b1;
              state_q       <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (lcd_response) begin
              lcd_command_q           <= 1'b0;
              req_response_q[grant_q] <= 1'b1;
              state_q                 <= S_ACK;
            end
          end
          S_ACK: begin
            // If the requester already dropped its command, the response is a 1-cycle pulse.
            if (!req_command[grant_q]) begin
              req_response_q <= '0;
              state_q        <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (!lcd_response) begin
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign req_response = req_response_q;
  assign lcd_command  = lcd_command_q;
  assign lcd_x        = lcd_x_q;
  assign lcd_y        = lcd_y_q;
  assign lcd_ascii    = lcd_ascii_q;
  assign grant_idx    = grant_q;
  assign arb_busy     = (state_q != S_IDLE);
  assign dbg_state    = state_q;

endmodule
